decode_stage: RTL

Pipelined RISC-V instruction-decode stage for the fetch → decode → execute path. Takes 32-bit instructions plus PC from fetch over a valid/ready handshake. Splits out the register fields, classifies the format (R/I/S/B/U/J) and builds the immediate sign-extended to XLEN. Results are buffered in a small FIFO so execute can stall without a combinational ready path back to fetch.

---
 rtl/decode_stage_if.sv | 47 ++++
 rtl/decode_stage.sv | 128 ++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
// out_illegal exists only when DECODE_ILLEGAL_EN is defined.
interface decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_imm;
    logic [CW-1:0]   out_count;
`ifdef DECODE_ILLEGAL_EN
    logic            out_illegal;
`endif

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
               out_rs1, out_rs2, out_rd, out_fmt, out_imm, out_count
`ifdef DECODE_ILLEGAL_EN
             , out_illegal
`endif
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
               out_rs1, out_rs2, out_rd, out_fmt, out_imm, out_count
`ifdef DECODE_ILLEGAL_EN
             , out_illegal
`endif
    );
endinterface

// File: rtl/decode_stage.sv
// RISC-V decode stage: combinational decode into a DEPTH-entry FIFO toward execute.
// Optional DECODE_ILLEGAL_EN adds a per-entry illegal-instruction flag.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input logic           clk,
    input logic           rst_n,
    input logic           flush,
    decode_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
`ifdef DECODE_ILLEGAL_EN
        logic            illegal;
`endif
    } entry_t;

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [DEPTH];
    entry_t        dec, head;
    logic [31:0]   instr, imm32;
    logic [2:0]    fmt;
    logic          in_ready, out_valid, push, pop;

    always_comb begin
        instr = bus.in_instr;
        imm32 = '0;
        fmt   = 3'd6;
        case (instr[6:0])
            7'b0110011: fmt = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                fmt   = 3'd1;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0100011: begin
                fmt   = 3'd2;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                fmt   = 3'd3;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                fmt   = 3'd4;
                imm32 = {instr[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt   = 3'd5;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        dec       = '0;
        dec.pc    = bus.in_pc;
        dec.instr = instr;
        dec.fmt   = fmt;
        dec.imm   = XLEN'($signed(imm32));
`ifdef DECODE_ILLEGAL_EN
        // func7 must be 0000000/0100000 for OP and for OP-IMM shifts; RV32 shamt is only 5 bits
        dec.illegal = (fmt == 3'd6) || (instr[1:0] != 2'b11)
            || ((instr[6:0] == 7'b0110011) && !(instr[31:25] inside {7'h00, 7'h20}))
            || ((instr[6:0] == 7'b0010011) && (instr[14:12] inside {3'b001, 3'b101})
                && (!(instr[31:25] inside {7'h00, 7'h20}) || ((XLEN == 32) && instr[25])));
`endif
    end

    // in_ready looks only at the registered count, so no path from out_ready back to fetch
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid & in_ready & ~flush;
    assign pop       = out_valid & bus.out_ready & ~flush;

    always_comb begin
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= dec;
    end

    assign head           = out_valid ? mem_q[rptr_q] : '0;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_pc     = head.pc;
    assign bus.out_opcode = head.instr[6:0];
    assign bus.out_func3  = head.instr[14:12];
    assign bus.out_func7  = head.instr[31:25];
    assign bus.out_rs1    = head.instr[19:15];
    assign bus.out_rs2    = head.instr[24:20];
    assign bus.out_rd     = head.instr[11:7];
    assign bus.out_fmt    = head.fmt;
    assign bus.out_imm    = head.imm;
    assign bus.out_count  = count_q;
`ifdef DECODE_ILLEGAL_EN
    assign bus.out_illegal = head.illegal;
`endif
endmodule
